// File: rtl/int_to_fp_pkg.sv
// Shared constants for the integer to floating-point pipeline: default widths
// and the rounding-mode encodings.
package int_to_fp_pkg;

    localparam int unsigned IN_W_DEF  = 32;
    localparam int unsigned MAN_W_DEF = 11;
    localparam int unsigned EXP_W_DEF = 5;

    localparam logic RND_TRUNC = 1'b0;
    localparam logic RND_RNE   = 1'b1;

endpackage

// File: rtl/int_to_fp_pipe_lead_one_det.sv
// Combinational leading-one detector: index of the most significant set bit
// plus a flag for an all-zero input.
module lead_one_det
    import int_to_fp_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned MSO_W = $clog2(IN_W)
) (
    input  logic [IN_W-1:0]  data_i,
    output logic [MSO_W-1:0] mso_o,
    output logic             zero_o
);

    // Ascending scan: the last set bit seen wins, leaving the highest index.
    always_comb begin
        mso_o = '0;
        for (int i = 0; i < int'(IN_W); i++) begin
            if (data_i[i]) begin
                mso_o = MSO_W'(i);
            end
        end
    end

    assign zero_o = ~|data_i;

endmodule

// File: rtl/int_to_fp_pipe.sv
// Two-stage valid/ready pipeline converting an unsigned integer into an
// {exponent offset, mantissa} pair with optional round-to-nearest-even.
module int_to_fp_pipe
    import int_to_fp_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned MAN_W = MAN_W_DEF,
    parameter int unsigned EXP_W = EXP_W_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [IN_W-1:0]        in_data_i,
    input  logic                   in_rnd_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [EXP_W+MAN_W-1:0] out_data_o,
    output logic                   out_sat_o
);

    localparam int unsigned MSO_W  = $clog2(IN_W);
    localparam int unsigned OUT_W  = EXP_W + MAN_W;
    localparam int unsigned MANX_W = MAN_W + 1;
    localparam int unsigned E_MIN  = MAN_W - 1;

    if (!(MAN_W < IN_W)) begin : g_bad_man_w
        $error("int_to_fp_pipe: MAN_W must be smaller than IN_W");
    end
    if (!((2 ** EXP_W) > (IN_W - MAN_W))) begin : g_bad_exp_w
        $error("int_to_fp_pipe: EXP_W too narrow for IN_W-MAN_W");
    end

    logic [MSO_W-1:0] det_mso;
    logic             det_zero;

    logic             v1_q, v1_d;
    logic [IN_W-1:0]  data1_q, data1_d;
    logic             rnd1_q, rnd1_d;
    logic [MSO_W-1:0] mso1_q, mso1_d;
    logic             zero1_q, zero1_d;

    logic             v2_q, v2_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             sat_q, sat_d;

    logic             s1_adv, s2_adv, accept;

    logic [MSO_W-1:0]  e_c, sh_c;
    logic [IN_W-1:0]   mask_c, half_c, rem_c;
    logic [MAN_W-1:0]  man_c, man_res_c;
    logic [MANX_W-1:0] man_inc_c;
    logic [EXP_W-1:0]  exp_c;
    logic              round_up_c, sat_c;

    lead_one_det #(
        .IN_W  (IN_W),
        .MSO_W (MSO_W)
    ) u_lod (
        .data_i (in_data_i),
        .mso_o  (det_mso),
        .zero_o (det_zero)
    );

    assign s2_adv     = !v2_q || out_ready_i;
    assign s1_adv     = !v1_q || s2_adv;
    assign in_ready_o = !rst_i && s1_adv;
    assign accept     = in_valid_i && in_ready_o;

    // Stage 2 datapath: align, round, and handle mantissa overflow / saturation.
    always_comb begin
        e_c        = (zero1_q || (mso1_q < MSO_W'(E_MIN))) ? MSO_W'(E_MIN) : mso1_q;
        sh_c       = e_c - MSO_W'(E_MIN);
        man_c      = MAN_W'(data1_q >> sh_c);
        mask_c     = (IN_W'(1) << sh_c) - IN_W'(1);
        rem_c      = data1_q & mask_c;
        half_c     = (sh_c == '0) ? '0 : (IN_W'(1) << (sh_c - MSO_W'(1)));
        round_up_c = (rnd1_q == RND_RNE) && (sh_c != '0) &&
                     ((rem_c > half_c) || ((rem_c == half_c) && man_c[0]));
        man_inc_c  = {1'b0, man_c} + MANX_W'(1);
        exp_c      = EXP_W'(sh_c);
        man_res_c  = man_c;
        sat_c      = 1'b0;
        if (round_up_c) begin
            if (!man_inc_c[MAN_W]) begin
                man_res_c = man_inc_c[MAN_W-1:0];
            end else if (e_c == MSO_W'(IN_W - 1)) begin
                exp_c     = EXP_W'(IN_W - MAN_W);
                man_res_c = '1;
                sat_c     = 1'b1;
            end else begin
                exp_c     = EXP_W'(sh_c) + EXP_W'(1);
                man_res_c = MAN_W'(1) << (MAN_W - 1);
            end
        end
    end

    always_comb begin
        v1_d    = v1_q;
        data1_d = data1_q;
        rnd1_d  = rnd1_q;
        mso1_d  = mso1_q;
        zero1_d = zero1_q;
        v2_d    = v2_q;
        out_d   = out_q;
        sat_d   = sat_q;
        if (s1_adv) begin
            v1_d = accept;
            if (accept) begin
                data1_d = in_data_i;
                rnd1_d  = in_rnd_i;
                mso1_d  = det_mso;
                zero1_d = det_zero;
            end
        end
        if (s2_adv) begin
            v2_d = v1_q;
            if (v1_q) begin
                out_d = {exp_c, man_res_c};
                sat_d = sat_c;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1_q    <= 1'b0;
            data1_q <= '0;
            rnd1_q  <= RND_TRUNC;
            mso1_q  <= '0;
            zero1_q <= 1'b0;
            v2_q    <= 1'b0;
            out_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            data1_q <= data1_d;
            rnd1_q  <= rnd1_d;
            mso1_q  <= mso1_d;
            zero1_q <= zero1_d;
            v2_q    <= v2_d;
            out_q   <= out_d;
            sat_q   <= sat_d;
        end
    end

    assign out_valid_o = v2_q;
    assign out_data_o  = out_q;
    assign out_sat_o   = sat_q;

endmodule

// File: tb/tb_int_to_fp_pipe.sv
// Directed and scoreboarded stimulus for int_to_fp_pipe at 32/11/5.
module tb_int_to_fp_pipe;
    import int_to_fp_pkg::*;

    localparam int unsigned IN_W  = 32;
    localparam int unsigned MAN_W = 11;
    localparam int unsigned EXP_W = 5;
    localparam int unsigned OUT_W = EXP_W + MAN_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_rnd;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;

    int checks   = 0;
    int failures = 0;

    logic [OUT_W:0] exp_q[$];

    int_to_fp_pipe #(
        .IN_W  (IN_W),
        .MAN_W (MAN_W),
        .EXP_W (EXP_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_rnd_i    (in_rnd),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_sat_o   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: {sat, exponent, mantissa} via 64-bit integer arithmetic.
    function automatic logic [OUT_W:0] model(input logic [31:0] d, input logic r);
        int                mso;
        int                e;
        int                s;
        int                ex;
        logic              sat;
        longint unsigned   dd;
        longint unsigned   man;
        longint unsigned   rem;
        longint unsigned   unit;
        mso = -1;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) mso = i;
        end
        e    = (mso < 10) ? 10 : mso;
        s    = e - 10;
        dd   = 64'(d);
        man  = dd >> s;
        rem  = dd - (man << s);
        unit = 64'd1 << s;
        ex   = s;
        sat  = 1'b0;
        if (r && (s > 0) && ((2 * rem > unit) || ((2 * rem == unit) && man[0]))) begin
            man = man + 1;
            if (man == 2048) begin
                if (e == 31) begin
                    sat = 1'b1;
                    man = 2047;
                end else begin
                    ex  = ex + 1;
                    man = 1024;
                end
            end
        end
        return {sat, 5'(ex), 11'(man)};
    endfunction

    task automatic send_one(input int idx, input logic [31:0] d, input logic r,
                            input logic [15:0] exp_d, input logic exp_s);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_rnd   = r;
        #1;
        chk($sformatf("vec%0d_rdy", idx), 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk($sformatf("vec%0d_lat1", idx), 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d_vld", idx), 64'(out_valid), 64'd1);
        chk($sformatf("vec%0d_data", idx), 64'(out_data), 64'(exp_d));
        chk($sformatf("vec%0d_sat", idx), 64'(out_sat), 64'(exp_s));
        @(posedge clk);
    endtask

    task automatic sb_cycle(input logic iv, input logic ordy);
        logic [OUT_W:0] e;
        @(negedge clk);
        in_valid  = iv;
        in_data   = $urandom;
        if ($urandom_range(0, 3) == 0) in_data = in_data >> $urandom_range(0, 31);
        in_rnd    = 1'($urandom_range(0, 1));
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", 64'({out_sat, out_data}), 64'(e));
            end
        end
        if (in_valid && in_ready) exp_q.push_back(model(in_data, in_rnd));
    endtask

    logic [31:0] vd[16];
    logic        vr[16];
    logic [15:0] ve[16];
    logic        vs[16];

    initial begin
        vd[0]  = 32'h0000_0000; vr[0]  = RND_TRUNC; ve[0]  = 16'h0000; vs[0]  = 1'b0;
        vd[1]  = 32'h0000_07FF; vr[1]  = RND_TRUNC; ve[1]  = 16'h07FF; vs[1]  = 1'b0;
        vd[2]  = 32'h0000_0FFF; vr[2]  = RND_TRUNC; ve[2]  = 16'h0FFF; vs[2]  = 1'b0;
        vd[3]  = 32'h0000_0FFF; vr[3]  = RND_RNE;   ve[3]  = 16'h1400; vs[3]  = 1'b0;
        vd[4]  = 32'hFFFF_FFFF; vr[4]  = RND_TRUNC; ve[4]  = 16'hAFFF; vs[4]  = 1'b0;
        vd[5]  = 32'hFFFF_FFFF; vr[5]  = RND_RNE;   ve[5]  = 16'hAFFF; vs[5]  = 1'b1;
        vd[6]  = 32'h0000_0001; vr[6]  = RND_TRUNC; ve[6]  = 16'h0001; vs[6]  = 1'b0;
        vd[7]  = 32'h8000_0000; vr[7]  = RND_RNE;   ve[7]  = 16'hAC00; vs[7]  = 1'b0;
        vd[8]  = 32'hFFF0_0000; vr[8]  = RND_RNE;   ve[8]  = 16'hAFFF; vs[8]  = 1'b1;
        vd[9]  = 32'hFFE0_0000; vr[9]  = RND_RNE;   ve[9]  = 16'hAFFF; vs[9]  = 1'b0;
        vd[10] = 32'h0000_1FFF; vr[10] = RND_RNE;   ve[10] = 16'h1C00; vs[10] = 1'b0;
        vd[11] = 32'h0000_1FFF; vr[11] = RND_TRUNC; ve[11] = 16'h17FF; vs[11] = 1'b0;
        vd[12] = 32'h0000_1802; vr[12] = RND_RNE;   ve[12] = 16'h1600; vs[12] = 1'b0;
        vd[13] = 32'h0000_1806; vr[13] = RND_RNE;   ve[13] = 16'h1602; vs[13] = 1'b0;
        vd[14] = 32'h0000_0000; vr[14] = RND_RNE;   ve[14] = 16'h0000; vs[14] = 1'b0;
        vd[15] = 32'h0000_07FF; vr[15] = RND_RNE;   ve[15] = 16'h07FF; vs[15] = 1'b0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_rnd    = RND_TRUNC;
        out_ready = 1'b0;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_sat", 64'(out_sat), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;

        for (int i = 0; i < 16; i++) begin
            send_one(i, vd[i], vr[i], ve[i], vs[i]);
        end

        // Backpressure: two samples fill the pipe, the third waits.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_rnd    = RND_RNE;
        in_data   = 32'h0000_0800;
        #1;
        chk("bp_rdy_a", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_data = 32'h0000_1000;
        #1;
        chk("bp_rdy_b", 64'(in_ready), 64'd1);
        chk("bp_vld_b", 64'(out_valid), 64'd0);
        @(negedge clk);
        in_data = 32'h0000_1801;
        #1;
        chk("bp_stall1_rdy", 64'(in_ready), 64'd0);
        chk("bp_stall1_data", 64'(out_data), 64'h0C00);
        @(negedge clk);
        #1;
        chk("bp_stall2_rdy", 64'(in_ready), 64'd0);
        chk("bp_stall2_data", 64'(out_data), 64'h0C00);
        @(negedge clk);
        #1;
        chk("bp_stall3_rdy", 64'(in_ready), 64'd0);
        chk("bp_stall3_vld", 64'(out_valid), 64'd1);
        chk("bp_stall3_data", 64'(out_data), 64'h0C00);
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("bp_out2_vld", 64'(out_valid), 64'd1);
        chk("bp_out2_data", 64'(out_data), 64'h1400);
        @(negedge clk);
        #1;
        chk("bp_out3_vld", 64'(out_valid), 64'd1);
        chk("bp_out3_data", 64'(out_data), 64'h1600);
        @(negedge clk);
        #1;
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Random valid/ready traffic, then a sustained full-rate burst.
        for (int i = 0; i < 250; i++) begin
            sb_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 30; i++) begin
            sb_cycle(1'b1, 1'b1);
            chk("full_rate_rdy", 64'(in_ready), 64'd1);
        end
        for (int i = 0; i < 6; i++) begin
            sb_cycle(1'b0, 1'b1);
        end
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        // Reset with both stages full.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_rnd    = RND_TRUNC;
        in_data   = 32'h0000_1234;
        @(negedge clk);
        in_data = 32'h0000_5678;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("full_vld", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        chk("mid_rst_sat", 64'(out_sat), 64'd0);
        chk("mid_rst_rdy", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_rst_rdy", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_stale", 64'(out_valid), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/int_to_fp_pipe.md
INT_TO_FP_PIPE -- requirements
Module: int_to_fp_pipe

Interface
REQ-001 Parameter IN_W, default 32, unsigned integer input width.
REQ-002 Parameter MAN_W, default 11, mantissa field width (MAN_W < IN_W).
REQ-003 Parameter EXP_W, default 5, exponent-offset field width; elaboration SHALL fail unless 2^EXP_W > IN_W-MAN_W.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  input sample valid.
REQ-007 in_ready  output  1  block accepts sample this cycle.
REQ-008 in_data  input  IN_W  unsigned integer sample (e.g. Sobol value).
REQ-009 in_rnd  input  1  rounding mode, sampled with in_data: 0 = truncate, 1 = round-to-nearest-even.
REQ-010 out_valid  output  1  output result valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 out_data  output  EXP_W+MAN_W  {exponent offset, mantissa}.
REQ-013 out_sat  output  1  result was saturated by rounding overflow.

Function
REQ-014 Transfer on a port SHALL occur only on a cycle with valid and ready both high.
REQ-015 MSO = index of most significant one of in_data; E = max(MSO, MAN_W-1); 0 gives E = MAN_W-1.
REQ-016 Exponent field = E-(MAN_W-1), range 0..IN_W-MAN_W; mantissa = in_data[E -: MAN_W].
REQ-017 Truncate mode: dropped bits in_data[E-MAN_W:0] SHALL be discarded; out_sat = 0.
REQ-018 RNE mode: round up if dropped bits > half LSB, or = half and mantissa LSB = 1; no dropped bits when E = MAN_W-1.
REQ-019 Mantissa round-up overflow SHALL give exponent+1, mantissa = 1 followed by MAN_W-1 zeros.
REQ-020 Overflow at max exponent (E = IN_W-1) SHALL saturate to {IN_W-MAN_W, all-ones mantissa}, out_sat = 1.
REQ-021 Pipeline: stage 1 registers data, rounding mode and MSO; stage 2 registers shifted, rounded result and sat flag.
REQ-022 Latency: accept at edge k, no backpressure -> out_valid high after edge k+2; throughput one per cycle.
REQ-023 Each stage SHALL advance when empty or when downstream accepts; in_ready = stage 1 empty or stage 1 advancing (combinational from out_ready allowed).
REQ-024 While out_valid=1 and out_ready=0, out_data and out_sat SHALL hold stable; no sample dropped, duplicated or reordered.
REQ-025 Simultaneous accept and emit in one cycle SHALL sustain full throughput without a bubble.

Reset
REQ-026 rst asserted SHALL immediately clear both stage valid bits: out_valid = 0, out_data = 0, out_sat = 0.
REQ-027 During reset in_ready = 0; first cycle after deassertion in_ready = 1.
REQ-028 Reset mid-operation SHALL discard all in-flight samples; none emerge after release.

Structure
REQ-029 Package int_to_fp_pkg SHALL hold rounding-mode constants (RND_TRUNC = 0, RND_RNE = 1) and default IN_W/MAN_W/EXP_W.
REQ-030 One sub-module lead_one_det (parametrised IN_W -> MSO index, zero flag), combinational, instantiated in stage 1.

Verification (IN_W=32, MAN_W=11, EXP_W=5)
REQ-031 in_data 0x00000000 and 0x000007FF, truncate -> out_data 0x0000 and 0x07FF, out_sat 0, two cycles after accept.
REQ-032 in_data 0x00000FFF: truncate -> 0x0FFF; RNE -> 0x1400 (mantissa overflow bumps exponent to 2).
REQ-033 in_data 0xFFFFFFFF: truncate -> 0xAFFF, out_sat 0; RNE -> 0xAFFF, out_sat 1.
REQ-034 Stream 0x800, 0x1000, 0x1801 (RNE), out_ready low 3 cycles -> in_ready drops after two held, outputs 0x0C00, 0x1400, 0x1600 in order.
REQ-035 Random back-to-back stream vs. reference model, random out_ready -> exact match, no loss, full rate at out_ready=1.
REQ-036 Assert rst with both stages full -> out_valid low immediately; after release no stale output.
